// File: rtl/branch_predictor_pkg.sv
// ============================================================================
// Module      : branch_predictor_pkg
// Description : Shared defines and types for the IF-stage branch predictor.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

`ifndef ADDR_SIZE
`define ADDR_SIZE 32
`endif
`ifndef BP_SNT
`define BP_SNT 2'b00
`endif
`ifndef BP_WNT
`define BP_WNT 2'b01
`endif
`ifndef BP_ST
`define BP_ST 2'b10
`endif
`ifndef BP_WT
`define BP_WT 2'b11
`endif
`ifndef BP_MISS_STATE
`define BP_MISS_STATE (`BP_WNT)
`endif

package branch_predictor_pkg;

   localparam int BP_INDEX_BITS = 6;

   typedef enum logic [1:0] {
      ST_SNT = `BP_SNT,
      ST_WNT = `BP_WNT,
      ST_ST  = `BP_ST,
      ST_WT  = `BP_WT
   } bp_state_e;

   localparam logic [1:0] BP_MISS_STATE = `BP_MISS_STATE;

   // Both taken encodings share the upper bit.
   function automatic logic state_is_taken(input logic [1:0] s);
      return s[1];
   endfunction

endpackage

`default_nettype wire

// File: rtl/bp_table.sv
// ============================================================================
// Module      : bp_table
// Description : Direct-mapped BHT/BTB storage; async read, sync write,
//               synchronous clear of the valid vector.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module bp_table
   import branch_predictor_pkg::*;
#(
   parameter int INDEX_BITS  = BP_INDEX_BITS,
   parameter int TAG_BITS    = 24,
   parameter int TARGET_BITS = 32
) (
   input  logic                   clk,
   input  logic                   reset,
   input  logic [INDEX_BITS-1:0]  rd_idx,
   output logic                   rd_valid,
   output logic [TAG_BITS-1:0]    rd_tag,
   output logic [1:0]             rd_state,
   output logic [TARGET_BITS-1:0] rd_target,
   input  logic                   wr_en,
   input  logic [INDEX_BITS-1:0]  wr_idx,
   input  logic [TAG_BITS-1:0]    wr_tag,
   input  logic [1:0]             wr_state,
   input  logic [TARGET_BITS-1:0] wr_target
);

   localparam int ENTRIES = 1 << INDEX_BITS;

   logic [ENTRIES-1:0]     valid_q;
   logic [ENTRIES-1:0]     valid_d;
   logic [TAG_BITS-1:0]    tag_q    [ENTRIES];
   logic [1:0]             state_q  [ENTRIES];
   logic [TARGET_BITS-1:0] target_q [ENTRIES];

   always_comb begin
      valid_d = valid_q;
      if (wr_en) valid_d[wr_idx] = 1'b1;
   end

   always_ff @(posedge clk) begin
      if (reset) valid_q <= '0;
      else       valid_q <= valid_d;
   end

   // Payload arrays carry no reset; a clear valid bit masks stale contents.
   always_ff @(posedge clk) begin
      if (wr_en) begin
         tag_q[wr_idx]    <= wr_tag;
         state_q[wr_idx]  <= wr_state;
         target_q[wr_idx] <= wr_target;
      end
   end

   assign rd_valid  = valid_q[rd_idx];
   assign rd_tag    = tag_q[rd_idx];
   assign rd_state  = state_q[rd_idx];
   assign rd_target = target_q[rd_idx];

endmodule

`default_nettype wire

// File: rtl/branch_predictor.sv
// ============================================================================
// Module      : branch_predictor
// Description : IF-stage 2-bit branch history table plus target buffer.
//               Optional counters enabled by defining BP_STATS_EN.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module branch_predictor
   import branch_predictor_pkg::*;
#(
   parameter int INDEX_BITS = BP_INDEX_BITS,
   parameter int TAG_BITS   = `ADDR_SIZE - INDEX_BITS - 2
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic [`ADDR_SIZE-1:0] IF_pc,
   input  logic [`ADDR_SIZE-1:0] IF_pcplus4,
   output logic                  pred_taken,
   output logic [`ADDR_SIZE-1:0] pred_pc,
   output logic [1:0]            prediction_state,
   input  logic                  upd_valid,
   input  logic                  stall,
   input  logic [`ADDR_SIZE-1:0] IDEX_pc,
   input  logic [1:0]            new_state,
   input  logic [`ADDR_SIZE-1:0] upd_target,
   input  logic                  upd_mispredict
`ifdef BP_STATS_EN
   ,
   output logic [31:0]           stat_updates,
   output logic [31:0]           stat_mispredicts
`endif
);

   logic [INDEX_BITS-1:0]  rd_idx;
   logic                   rd_valid;
   logic [TAG_BITS-1:0]    rd_tag;
   logic [1:0]             rd_state;
   logic [`ADDR_SIZE-1:0]  rd_target;
   logic                   hit;
   logic                   upd_accept;

   assign rd_idx = IF_pc[INDEX_BITS+1:2];

   // Reset dominates a coincident update; stall discards the unheld new_state.
   assign upd_accept = upd_valid && !stall && !reset;

   bp_table #(
      .INDEX_BITS  (INDEX_BITS),
      .TAG_BITS    (TAG_BITS),
      .TARGET_BITS (`ADDR_SIZE)
   ) u_table (
      .clk       (clk),
      .reset     (reset),
      .rd_idx    (rd_idx),
      .rd_valid  (rd_valid),
      .rd_tag    (rd_tag),
      .rd_state  (rd_state),
      .rd_target (rd_target),
      .wr_en     (upd_accept),
      .wr_idx    (IDEX_pc[INDEX_BITS+1:2]),
      .wr_tag    (IDEX_pc[`ADDR_SIZE-1:INDEX_BITS+2]),
      .wr_state  (new_state),
      .wr_target (upd_target)
   );

   assign hit = rd_valid && (rd_tag == IF_pc[`ADDR_SIZE-1:INDEX_BITS+2]);

   always_comb begin
      prediction_state = BP_MISS_STATE;
      pred_taken       = 1'b0;
      pred_pc          = IF_pcplus4;
      if (hit) begin
         prediction_state = rd_state;
         pred_taken       = state_is_taken(rd_state);
         if (pred_taken) pred_pc = rd_target;
      end
   end

   // Byte-offset bits never address the table; upd_mispredict only feeds stats.
   logic unused_bits;
   assign unused_bits = ^{IF_pc[1:0], IDEX_pc[1:0], upd_mispredict};

`ifdef BP_STATS_EN
   logic [31:0] stat_updates_q;
   logic [31:0] stat_updates_d;
   logic [31:0] stat_mispredicts_q;
   logic [31:0] stat_mispredicts_d;

   always_comb begin
      stat_updates_d     = stat_updates_q;
      stat_mispredicts_d = stat_mispredicts_q;
      if (upd_accept) begin
         if (stat_updates_q != 32'hFFFF_FFFF) stat_updates_d = stat_updates_q + 32'd1;
         if (upd_mispredict && (stat_mispredicts_q != 32'hFFFF_FFFF))
            stat_mispredicts_d = stat_mispredicts_q + 32'd1;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         stat_updates_q     <= '0;
         stat_mispredicts_q <= '0;
      end else begin
         stat_updates_q     <= stat_updates_d;
         stat_mispredicts_q <= stat_mispredicts_d;
      end
   end

   assign stat_updates     = stat_updates_q;
   assign stat_mispredicts = stat_mispredicts_q;
`endif

endmodule

`default_nettype wire

// File: tb/tb_branch_predictor.sv
// ============================================================================
// Module      : tb_branch_predictor
// Description : Self-checking bench for branch_predictor against a table model.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

`ifndef ADDR_SIZE
`define ADDR_SIZE 32
`endif

module tb_branch_predictor;

   localparam int AW = `ADDR_SIZE;

   logic          clk;
   logic          reset;
   logic [AW-1:0] IF_pc;
   logic [AW-1:0] IF_pcplus4;
   logic          pred_taken;
   logic [AW-1:0] pred_pc;
   logic [1:0]    prediction_state;
   logic          upd_valid;
   logic          stall;
   logic [AW-1:0] IDEX_pc;
   logic [1:0]    new_state;
   logic [AW-1:0] upd_target;
   logic          upd_mispredict;
`ifdef BP_STATS_EN
   logic [31:0]   stat_updates;
   logic [31:0]   stat_mispredicts;
`endif

   int vectors;
   int miscompares;

   // Reference model: 64 direct-mapped entries keyed by word address.
   bit            m_valid  [64];
   longint        m_tag    [64];
   logic [1:0]    m_state  [64];
   logic [AW-1:0] m_target [64];
   longint        m_upd;
   longint        m_mis;

   branch_predictor dut (
      .clk              (clk),
      .reset            (reset),
      .IF_pc            (IF_pc),
      .IF_pcplus4       (IF_pcplus4),
      .pred_taken       (pred_taken),
      .pred_pc          (pred_pc),
      .prediction_state (prediction_state),
      .upd_valid        (upd_valid),
      .stall            (stall),
      .IDEX_pc          (IDEX_pc),
      .new_state        (new_state),
      .upd_target       (upd_target),
      .upd_mispredict   (upd_mispredict)
`ifdef BP_STATS_EN
      ,
      .stat_updates     (stat_updates),
      .stat_mispredicts (stat_mispredicts)
`endif
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Expected {pred_taken, prediction_state, pred_pc} for a fetch address.
   function automatic logic [AW+2:0] expect_lookup(input logic [AW-1:0] pc);
      int     idx;
      longint tg;
      idx = int'((pc / 4) % 64);
      tg  = longint'(pc / 256);
      if (m_valid[idx] && m_tag[idx] == tg) begin
         if (m_state[idx] == 2'b10 || m_state[idx] == 2'b11)
            return {1'b1, m_state[idx], m_target[idx]};
         return {1'b0, m_state[idx], pc + 32'd4};
      end
      return {1'b0, 2'b01, pc + 32'd4};
   endfunction

   task automatic model_commit();
      int idx;
      if (reset) begin
         for (int i = 0; i < 64; i++) m_valid[i] = 1'b0;
         m_upd = 0;
         m_mis = 0;
      end else if (upd_valid && !stall) begin
         idx = int'((IDEX_pc / 4) % 64);
         m_valid[idx]  = 1'b1;
         m_tag[idx]    = longint'(IDEX_pc / 256);
         m_state[idx]  = new_state;
         m_target[idx] = upd_target;
         m_upd++;
         if (upd_mispredict) m_mis++;
      end
   endtask

   // Clock edge: model absorbs the inputs the DUT samples, then idle the update port.
   task automatic tick();
      @(posedge clk);
      model_commit();
      @(negedge clk);
      reset          = 1'b0;
      upd_valid      = 1'b0;
      stall          = 1'b0;
      upd_mispredict = 1'b0;
   endtask

   task automatic set_pc(input logic [AW-1:0] pc);
      IF_pc      = pc;
      IF_pcplus4 = pc + 32'd4;
      #1;
   endtask

   task automatic set_upd(input logic [AW-1:0] pc, input logic [1:0] st,
                          input logic [AW-1:0] tgt, input logic stl, input logic mis);
      upd_valid      = 1'b1;
      IDEX_pc        = pc;
      new_state      = st;
      upd_target     = tgt;
      stall          = stl;
      upd_mispredict = mis;
   endtask

   task automatic test_reset();
      logic [AW+2:0] got;
      reset = 1'b1;
      tick();
      set_pc(32'h0000_0040);
      got = {pred_taken, prediction_state, pred_pc};
      vectors++;
      if (got !== {1'b0, 2'b01, 32'h0000_0044}) begin
         miscompares++;
         $display("FAIL reset_miss got=%h want=%h", got, {1'b0, 2'b01, 32'h0000_0044});
      end
`ifdef BP_STATS_EN
      vectors++;
      if ({stat_updates, stat_mispredicts} !== 64'd0) begin
         miscompares++;
         $display("FAIL reset_stats got=%h/%h want=0/0", stat_updates, stat_mispredicts);
      end
`endif
   endtask

   task automatic test_update_hit();
      logic [AW+2:0] got;
      set_upd(32'h40, 2'b10, 32'h80, 1'b0, 1'b0);
      tick();
      set_pc(32'h40);
      got = {pred_taken, prediction_state, pred_pc};
      vectors++;
      if (got !== {1'b1, 2'b10, 32'h0000_0080}) begin
         miscompares++;
         $display("FAIL update_hit got=%h want=%h", got, {1'b1, 2'b10, 32'h0000_0080});
      end
   endtask

   task automatic test_stall();
      logic [AW+2:0] got;
      reset = 1'b1;
      tick();
      set_upd(32'h40, 2'b10, 32'h80, 1'b1, 1'b1);
      tick();
      set_pc(32'h40);
      got = {pred_taken, prediction_state, pred_pc};
      vectors++;
      if (got !== {1'b0, 2'b01, 32'h0000_0044}) begin
         miscompares++;
         $display("FAIL stall_blocks got=%h want=%h", got, {1'b0, 2'b01, 32'h0000_0044});
      end
   endtask

   task automatic test_alias();
      logic [AW+2:0] got;
      set_upd(32'h40, 2'b11, 32'h200, 1'b0, 1'b0);
      tick();
      set_pc(32'h140);
      got = {pred_taken, prediction_state, pred_pc};
      vectors++;
      if (got !== {1'b0, 2'b01, 32'h0000_0144}) begin
         miscompares++;
         $display("FAIL alias_tag_miss got=%h want=%h", got, {1'b0, 2'b01, 32'h0000_0144});
      end
      set_upd(32'h140, 2'b00, 32'h300, 1'b0, 1'b0);
      tick();
      set_pc(32'h40);
      got = {pred_taken, prediction_state, pred_pc};
      vectors++;
      if (got !== {1'b0, 2'b01, 32'h0000_0044}) begin
         miscompares++;
         $display("FAIL alias_evict got=%h want=%h", got, {1'b0, 2'b01, 32'h0000_0044});
      end
      set_pc(32'h140);
      got = {pred_taken, prediction_state, pred_pc};
      vectors++;
      if (got !== {1'b0, 2'b00, 32'h0000_0144}) begin
         miscompares++;
         $display("FAIL alias_new_entry got=%h want=%h", got, {1'b0, 2'b00, 32'h0000_0144});
      end
   endtask

   task automatic test_same_cycle();
      logic [AW+2:0] got;
      set_upd(32'h40, 2'b10, 32'h80, 1'b0, 1'b0);
      tick();
      set_upd(32'h40, 2'b11, 32'h100, 1'b0, 1'b0);
      set_pc(32'h40);
      got = {pred_taken, prediction_state, pred_pc};
      vectors++;
      if (got !== {1'b1, 2'b10, 32'h0000_0080}) begin
         miscompares++;
         $display("FAIL same_cycle_old got=%h want=%h", got, {1'b1, 2'b10, 32'h0000_0080});
      end
      tick();
      set_pc(32'h40);
      got = {pred_taken, prediction_state, pred_pc};
      vectors++;
      if (got !== {1'b1, 2'b11, 32'h0000_0100}) begin
         miscompares++;
         $display("FAIL same_cycle_new got=%h want=%h", got, {1'b1, 2'b11, 32'h0000_0100});
      end
   endtask

   task automatic test_reset_with_update();
      logic [AW+2:0] got;
      logic [AW-1:0] pcs [3];
      pcs[0] = 32'h40; pcs[1] = 32'h140; pcs[2] = 32'h80;
      set_upd(32'h80, 2'b10, 32'h400, 1'b0, 1'b0);
      tick();
      set_upd(32'h80, 2'b11, 32'h500, 1'b0, 1'b1);
      reset = 1'b1;
      tick();
      foreach (pcs[i]) begin
         set_pc(pcs[i]);
         got = {pred_taken, prediction_state, pred_pc};
         vectors++;
         if (got !== {1'b0, 2'b01, pcs[i] + 32'd4}) begin
            miscompares++;
            $display("FAIL reset_wins pc=%h got=%h want=%h", pcs[i], got,
                     {1'b0, 2'b01, pcs[i] + 32'd4});
         end
      end
   endtask

`ifdef BP_STATS_EN
   task automatic test_stats();
      reset = 1'b1;
      tick();
      vectors++;
      if ({stat_updates, stat_mispredicts} !== 64'd0) begin
         miscompares++;
         $display("FAIL stats_clear got=%h/%h want=0/0", stat_updates, stat_mispredicts);
      end
      set_upd(32'h10, 2'b10, 32'h20, 1'b0, 1'b0); tick();
      set_upd(32'h14, 2'b00, 32'h24, 1'b0, 1'b1); tick();
      set_upd(32'h18, 2'b11, 32'h28, 1'b1, 1'b1); tick();
      set_upd(32'h1C, 2'b01, 32'h2C, 1'b0, 1'b0); tick();
      vectors++;
      if (stat_updates !== 32'd3 || stat_mispredicts !== 32'd1) begin
         miscompares++;
         $display("FAIL stats_count got=%0d/%0d want=3/1", stat_updates, stat_mispredicts);
      end
   endtask
`endif

   task automatic test_random();
      logic [AW+2:0] got;
      logic [AW+2:0] exp;
      logic [AW-1:0] pc;
      for (int n = 0; n < 400; n++) begin
         // Few tags over few indexes so hits, misses and aliasing all occur.
         pc = {22'd0, 2'($urandom_range(0, 3)), 6'($urandom_range(0, 7)), 2'b00};
         set_upd({22'd0, 2'($urandom_range(0, 3)), 6'($urandom_range(0, 7)), 2'b00},
                 2'($urandom), $urandom, 1'($urandom_range(0, 3) == 0), 1'($urandom));
         upd_valid = 1'($urandom_range(0, 2) != 0);
         reset     = 1'($urandom_range(0, 49) == 0);
         set_pc(pc);
         got = {pred_taken, prediction_state, pred_pc};
         exp = expect_lookup(pc);
         vectors++;
         if (got !== exp) begin
            miscompares++;
            $display("FAIL random_lookup n=%0d pc=%h got=%h want=%h", n, pc, got, exp);
         end
         tick();
      end
`ifdef BP_STATS_EN
      vectors++;
      if (stat_updates !== 32'(m_upd) || stat_mispredicts !== 32'(m_mis)) begin
         miscompares++;
         $display("FAIL random_stats got=%0d/%0d want=%0d/%0d",
                  stat_updates, stat_mispredicts, m_upd, m_mis);
      end
`endif
   endtask

   initial begin
      vectors        = 0;
      miscompares    = 0;
      m_upd          = 0;
      m_mis          = 0;
      reset          = 1'b0;
      upd_valid      = 1'b0;
      stall          = 1'b0;
      upd_mispredict = 1'b0;
      IDEX_pc        = '0;
      new_state      = 2'b00;
      upd_target     = '0;
      IF_pc          = '0;
      IF_pcplus4     = 32'd4;
      @(negedge clk);
      test_reset();
      test_update_hit();
      test_stall();
      test_alias();
      test_same_cycle();
      test_reset_with_update();
`ifdef BP_STATS_EN
      test_stats();
`endif
      test_random();
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule

`default_nettype wire
